// File: rtl/cpu_pkg.sv
// Shared cpu front-end types: widths, fetch FSM states and the bundle record.
package cpu_pkg;
   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;
   localparam int DEF_CORES = 4;

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0]              pc;
      logic [DEF_CORES*INSTR_W-1:0] data;
   } bundle_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry valid/ready FIFO holding fetched bundles, with synchronous flush.
module fetch_skid_buffer
   import cpu_pkg::*;
#(
   parameter type T = bundle_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush_i,
   input  logic       push_i,
   input  T           push_data_i,
   input  logic       pop_i,
   output logic       valid_o,
   output T           data_o,
   output logic [1:0] count_o
);
   T           mem_q [2];
   logic [1:0] cnt_q, cnt_d;
   logic       head_q, head_d;
   logic       do_pop, do_push, wr_idx;

   always_comb begin
      do_pop  = pop_i && (cnt_q != 2'd0);
      do_push = push_i && !flush_i;
      // tail slot; with a full buffer this is the slot being popped
      wr_idx  = head_q ^ cnt_q[0];
      cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      head_d  = head_q ^ do_pop;
      if (flush_i) begin
         cnt_d  = 2'd0;
         head_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         head_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_idx] <= push_data_i;
   end

   assign valid_o = (cnt_q != 2'd0);
   assign data_o  = mem_q[head_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/fetch_bundle_unit.sv
// PC, fetch FSM and bundle issue for the multi-core front end.
// Optional FETCH_PERF_EN adds transfer/redirect counters.
module fetch_bundle_unit
   import cpu_pkg::*;
#(
   parameter int          CORES    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [31:0]           imem_addr,
   output logic                  imem_req,
   input  logic [32*CORES-1:0]   imem_rdata,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_target,
   input  logic                  halt_req,
   output logic                  bundle_valid,
   input  logic                  bundle_ready,
   output logic [32*CORES-1:0]   bundle_data,
   output logic [31:0]           bundle_pc,
   output logic [31:0]           pcOut,
   output logic                  fetch_fault
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]           perf_bundles,
   output logic [31:0]           perf_redirects
`endif
);
   localparam logic [XLEN-1:0] STEP = XLEN'(4 * CORES);

   typedef struct packed {
      logic [XLEN-1:0]          pc;
      logic [CORES*INSTR_W-1:0] data;
   } fb_t;

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         infl_q, infl_d;
   logic [31:0]  infl_pc_q, infl_pc_d;
   logic         fault_q, fault_d;

   logic         redir_ok, redir_bad;
   logic         pop, push, issue;
   logic [1:0]   buf_cnt, occ;
   logic         buf_valid;
   fb_t          buf_in, buf_out;

   always_comb begin
      redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
      redir_bad = redirect_valid && !redir_ok;
      pop       = buf_valid && bundle_ready;
      // a head leaving this cycle frees its slot for the new request
      occ       = buf_cnt + {1'b0, infl_q} - {1'b0, pop};
      issue     = (state_q == FETCH) && (occ < 2'd2) && !redir_bad;
      push      = infl_q && !redir_ok;
      state_d   = state_q;
      pc_d      = pc_q;
      infl_d    = issue && !redir_ok;
      infl_pc_d = pc_q;
      fault_d   = fault_q || redir_bad;
      if (issue) pc_d = pc_q + STEP;
      if (redir_ok) pc_d = redirect_target;
      if (halt_req || redir_bad) state_d = HALT;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         infl_q    <= 1'b0;
         infl_pc_q <= RESET_PC;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         infl_q    <= infl_d;
         infl_pc_q <= infl_pc_d;
         fault_q   <= fault_d;
      end
   end

   assign buf_in = '{pc: infl_pc_q, data: imem_rdata};

   fetch_skid_buffer #(
      .T(fb_t)
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (redir_ok),
      .push_i     (push),
      .push_data_i(buf_in),
      .pop_i      (bundle_ready),
      .valid_o    (buf_valid),
      .data_o     (buf_out),
      .count_o    (buf_cnt)
   );

   assign imem_req     = issue;
   assign imem_addr    = pc_q;
   assign pcOut        = pc_q;
   assign fetch_fault  = fault_q;
   assign bundle_valid = buf_valid;
   assign bundle_pc    = buf_out.pc;
   assign bundle_data  = buf_out.data;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_b_q, perf_r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_b_q <= 32'd0;
         perf_r_q <= 32'd0;
      end else begin
         if (pop) perf_b_q <= perf_b_q + 32'd1;
         if (redir_ok) perf_r_q <= perf_r_q + 32'd1;
      end
   end

   assign perf_bundles   = perf_b_q;
   assign perf_redirects = perf_r_q;
`endif
endmodule
